// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch-stage, LSU and memory-side signals shared by the instruction-memory port arbiter.
// slave is the arbiter's view; master is the surrounding fetch/LSU/memory environment.
interface imem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_data;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ready;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_spurious;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ready, if_valid, if_data,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_ready, dm_valid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output err_spurious
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ready, if_valid, if_data,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_ready, dm_valid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  err_spurious
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between instruction fetch and the LSU, one access in flight,
// with a starvation cap on consecutive data grants and dropping of fetch responses made stale by a redirect.
module imem_port_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state, state_nxt;
  logic        kill, kill_nxt;
  logic [3:0]  streak, streak_nxt;
  logic        latched_we, latched_we_nxt;
  logic        err_q, err_nxt;
  logic        idle;
  logic        dm_win;
  logic        accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kill       <= 1'b0;
      streak     <= 4'd0;
      latched_we <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      streak     <= streak_nxt;
      latched_we <= latched_we_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    streak_nxt     = streak;
    latched_we_nxt = latched_we;
    err_nxt        = err_q;

    idle   = (state == IDLE);
    // Data wins unless a waiting fetch has already been passed over STREAK_MAX times in a row.
    dm_win = bus.dm_req & ~(bus.if_req & (streak == 4'(STREAK_MAX)));

    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'd0;
    bus.if_ready  = 1'b0;
    bus.dm_ready  = 1'b0;
    bus.if_valid  = 1'b0;
    bus.if_data   = 32'd0;
    bus.dm_valid  = 1'b0;
    bus.dm_rdata  = 32'd0;

    if (idle) begin
      bus.mem_req  = bus.if_req | bus.dm_req;
      bus.if_ready = bus.mem_gnt & ~dm_win;
      bus.dm_ready = bus.mem_gnt & dm_win;
      if (dm_win) begin
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
        bus.mem_wstrb = bus.dm_wstrb;
      end else begin
        bus.mem_addr  = bus.if_addr;
      end
    end
    accept = bus.mem_req & bus.mem_gnt;

    unique case (state)
      IDLE: begin
        if (bus.mem_rvalid)
          err_nxt = 1'b1;
        if (accept) begin
          if (dm_win) begin
            state_nxt      = BUSY_D;
            latched_we_nxt = bus.dm_we;
            if (bus.if_req)
              streak_nxt = (streak == 4'(STREAK_MAX)) ? streak : streak + 4'd1;
            else
              streak_nxt = 4'd0;
          end else begin
            state_nxt  = BUSY_I;
            streak_nxt = 4'd0;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_rvalid) begin
          // A redirect coinciding with the response drops it without arming kill.
          bus.if_valid = ~kill & ~bus.if_flush;
          bus.if_data  = bus.if_valid ? bus.mem_rdata : 32'd0;
          state_nxt    = IDLE;
          kill_nxt     = 1'b0;
        end else if (bus.if_flush) begin
          kill_nxt = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_rvalid) begin
          bus.dm_valid = 1'b1;
          bus.dm_rdata = latched_we ? 32'd0 : bus.mem_rdata;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    bus.err_spurious = err_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_imem_port_arbiter;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  imem_port_arbiter_if bus ();
  imem_port_arbiter #(.STREAK_MAX(SMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wstrb = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  // Transaction-level model state for the random phase
  int          owner;      // 0 none, 1 fetch, 2 data
  bit          p_we, p_stale, m_err;
  int          m_streak, wait_cyc;
  bit          data_first;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_we, e_ifv, e_dmv;
  logic [31:0] e_ifd, e_dmd;

  initial begin
    idle_inputs();
    reset = 1;
    nxt(); nxt();
    reset = 0;
    settle();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_err", bus.err_spurious, 0);
    chk("rst_valids", {bus.if_valid, bus.dm_valid}, 0);

    // Lone fetch, response three cycles after accept
    nxt();
    bus.if_req = 1; bus.if_addr = 32'h200; bus.mem_gnt = 1;
    settle();
    chk("lf_if_ready", bus.if_ready, 1);
    chk("lf_mem_req", bus.mem_req, 1);
    chk("lf_mem_addr", bus.mem_addr, 32'h200);
    chk("lf_mem_wstrb", bus.mem_wstrb, 0);
    chk("lf_mem_we", bus.mem_we, 0);
    nxt();
    bus.if_req = 0;
    settle();
    chk("lf_busy_mem_req", bus.mem_req, 0);
    chk("lf_busy_if_ready", bus.if_ready, 0);
    nxt(); nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h13;
    settle();
    chk("lf_if_valid", bus.if_valid, 1);
    chk("lf_if_data", bus.if_data, 32'h13);
    nxt();
    bus.mem_rvalid = 0;
    settle();
    chk("lf_after_valid", bus.if_valid, 0);

    // Simultaneous requests: data first, then fetch
    bus.if_req = 1; bus.if_addr = 32'h300; bus.dm_req = 1; bus.dm_addr = 32'h1000;
    #1;
    chk("sim_dm_ready", bus.dm_ready, 1);
    chk("sim_if_ready", bus.if_ready, 0);
    chk("sim_mem_addr", bus.mem_addr, 32'h1000);
    nxt();
    bus.dm_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE0001;
    settle();
    chk("sim_dm_valid", bus.dm_valid, 1);
    chk("sim_dm_rdata", bus.dm_rdata, 32'hCAFE0001);
    chk("sim_no_if_valid", bus.if_valid, 0);
    nxt();
    bus.mem_rvalid = 0;
    settle();
    chk("sim_if_ready2", bus.if_ready, 1);
    chk("sim_mem_addr2", bus.mem_addr, 32'h300);
    nxt();
    bus.if_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00100093;
    settle();
    chk("sim_if_valid", bus.if_valid, 1);
    chk("sim_if_data", bus.if_data, 32'h00100093);
    nxt();
    bus.mem_rvalid = 0;

    // Starvation cap: four data grants, then fetch, then data again
    bus.if_req = 1; bus.if_addr = 32'h500; bus.dm_req = 1; bus.dm_addr = 32'h2000;
    for (int g = 0; g < 6; g++) begin
      settle();
      chk($sformatf("stv_dm_ready%0d", g), bus.dm_ready, (g == 4) ? 0 : 1);
      chk($sformatf("stv_if_ready%0d", g), bus.if_ready, (g == 4) ? 1 : 0);
      nxt();
      bus.mem_rvalid = 1;
      nxt();
      bus.mem_rvalid = 0;
    end
    bus.if_req = 0; bus.dm_req = 0;

    // Flush while the fetch is in flight
    bus.if_req = 1; bus.if_addr = 32'h204;
    settle();
    chk("fl_if_ready", bus.if_ready, 1);
    nxt();
    bus.if_req = 0; bus.if_flush = 1;
    nxt();
    bus.if_flush = 0;
    nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0;
    settle();
    chk("fl_dropped", bus.if_valid, 0);
    chk("fl_dropped_data", bus.if_data, 0);
    nxt();
    bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h400;
    settle();
    chk("fl_next_ready", bus.if_ready, 1);
    chk("fl_next_addr", bus.mem_addr, 32'h400);
    nxt();
    bus.if_req = 0;
    nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h00000517;
    settle();
    chk("fl_next_valid", bus.if_valid, 1);
    chk("fl_next_data", bus.if_data, 32'h00000517);
    nxt();
    bus.mem_rvalid = 0;

    // Flush coinciding with the response
    bus.if_req = 1; bus.if_addr = 32'h600;
    nxt();
    bus.if_req = 0; bus.if_flush = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111;
    settle();
    chk("flr_dropped", bus.if_valid, 0);
    nxt();
    bus.if_flush = 0; bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h604;
    nxt();
    bus.if_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h2222;
    settle();
    chk("flr_no_kill", bus.if_valid, 1);
    nxt();
    bus.mem_rvalid = 0;

    // Store pass-through and acknowledge
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h3000; bus.dm_wstrb = 4'b0011; bus.dm_wdata = 32'hDEADBEEF;
    settle();
    chk("st_dm_ready", bus.dm_ready, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_wstrb", bus.mem_wstrb, 4'b0011);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("st_mem_addr", bus.mem_addr, 32'h3000);
    nxt();
    bus.dm_req = 0; bus.dm_we = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
    settle();
    chk("st_dm_valid", bus.dm_valid, 1);
    chk("st_dm_rdata", bus.dm_rdata, 0);
    nxt();
    bus.mem_rvalid = 0;

    // Reset while a load is outstanding
    bus.dm_req = 1; bus.dm_addr = 32'h4000;
    nxt();
    bus.dm_req = 0; reset = 1;
    nxt();
    reset = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    settle();
    chk("rmo_no_dm_valid", bus.dm_valid, 0);
    nxt();
    bus.mem_rvalid = 0;
    settle();
    chk("rmo_err_set", bus.err_spurious, 1);
    nxt(); nxt();
    settle();
    chk("rmo_err_sticky", bus.err_spurious, 1);
    nxt();
    reset = 1;
    nxt();
    reset = 0;
    settle();
    chk("rmo_err_cleared", bus.err_spurious, 0);
    nxt();

    // Randomized run against the transaction-level model
    owner = 0; p_we = 0; p_stale = 0; m_err = 0; m_streak = 0; wait_cyc = 0;
    for (int c = 0; c < 2500; c++) begin
      bus.if_req   = ($urandom_range(0, 3) != 0);
      bus.if_addr  = $urandom & 32'hFFFF_FFFC;
      bus.if_flush = ($urandom_range(0, 5) == 0);
      bus.dm_req   = ($urandom_range(0, 2) != 0);
      bus.dm_we    = $urandom_range(0, 1);
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
      bus.dm_wstrb = 4'($urandom);
      bus.mem_gnt  = ($urandom_range(0, 3) != 0);
      bus.mem_rdata = $urandom;
      bus.mem_rvalid = 0;
      if (owner != 0) begin
        if (wait_cyc == 0) bus.mem_rvalid = 1;
        else wait_cyc--;
      end else if (c > 2400 && $urandom_range(0, 31) == 0) begin
        bus.mem_rvalid = 1;
      end
      settle();

      data_first = bus.dm_req && !(bus.if_req && m_streak == SMAX);
      e_ifv = 0; e_ifd = 0; e_dmv = 0; e_dmd = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      if (owner == 0) begin
        e_we    = data_first ? bus.dm_we : 1'b0;
        e_addr  = data_first ? bus.dm_addr : bus.if_addr;
        e_wdata = data_first ? bus.dm_wdata : 32'd0;
        e_wstrb = data_first ? bus.dm_wstrb : 4'd0;
      end else if (bus.mem_rvalid) begin
        if (owner == 1) begin
          e_ifv = !p_stale && !bus.if_flush;
          e_ifd = e_ifv ? bus.mem_rdata : 32'd0;
        end else begin
          e_dmv = 1;
          e_dmd = p_we ? 32'd0 : bus.mem_rdata;
        end
      end
      chk("rnd_mem_req", bus.mem_req, (owner == 0) && (bus.if_req || bus.dm_req));
      chk("rnd_if_ready", bus.if_ready, (owner == 0) && bus.mem_gnt && !data_first);
      chk("rnd_dm_ready", bus.dm_ready, (owner == 0) && bus.mem_gnt && data_first);
      chk("rnd_mem_we", bus.mem_we, e_we);
      chk("rnd_mem_addr", bus.mem_addr, e_addr);
      chk("rnd_mem_wdata", bus.mem_wdata, e_wdata);
      chk("rnd_mem_wstrb", bus.mem_wstrb, e_wstrb);
      chk("rnd_if_valid", bus.if_valid, e_ifv);
      chk("rnd_if_data", bus.if_data, e_ifd);
      chk("rnd_dm_valid", bus.dm_valid, e_dmv);
      chk("rnd_dm_rdata", bus.dm_rdata, e_dmd);
      chk("rnd_err", bus.err_spurious, m_err);

      if (owner == 0) begin
        if (bus.mem_rvalid) m_err = 1;
        if ((bus.if_req || bus.dm_req) && bus.mem_gnt) begin
          owner    = data_first ? 2 : 1;
          p_we     = data_first && bus.dm_we;
          p_stale  = 0;
          wait_cyc = $urandom_range(0, 2);
          if (data_first && bus.if_req) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
          else m_streak = 0;
        end
      end else if (bus.mem_rvalid) begin
        owner = 0;
      end else if (owner == 1 && bus.if_flush) begin
        p_stale = 1;
      end
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
